// File: rtl/seven_segment_scanner_pkg.sv
// seven_segment_scanner_pkg
// Shared definitions for the seven-segment display path: active-low glyph
// constants (bit0 = a ... bit6 = g), the segment bus width, the digit that
// carries the colon, and the scan-slot length derivation.
`timescale 1ns/1ps
package seven_segment_scanner_pkg;

  localparam int SEGMENT_WIDTH = 7;
  localparam int BCD_WIDTH     = 4;
  localparam int COLON_DIGIT   = 2;

  typedef logic [SEGMENT_WIDTH-1:0] segment_t;

  // Active-low: a 0 bit lights the segment.
  localparam segment_t GLYPH_0    = 7'h40;
  localparam segment_t GLYPH_1    = 7'h79;
  localparam segment_t GLYPH_2    = 7'h24;
  localparam segment_t GLYPH_3    = 7'h30;
  localparam segment_t GLYPH_4    = 7'h19;
  localparam segment_t GLYPH_5    = 7'h12;
  localparam segment_t GLYPH_6    = 7'h02;
  localparam segment_t GLYPH_7    = 7'h78;
  localparam segment_t GLYPH_8    = 7'h00;
  localparam segment_t GLYPH_9    = 7'h10;
  localparam segment_t GLYPH_DASH = 7'h3F;
  localparam segment_t GLYPH_OFF  = 7'h7F;

  // Clock cycles spent on each digit so that all digits are scanned
  // frame_hz times per second (integer division, remainder dropped).
  function automatic int slot_cycles(input int clk_hz, input int frame_hz,
                                     input int digits);
    return clk_hz / (frame_hz * digits);
  endfunction

endpackage

// File: rtl/seven_segment_scanner_bcd_to_segments.sv
// bcd_to_segments
// Combinational BCD to active-low seven-segment glyph. Codes above 9 show a
// dash so corrupted upstream values are visible rather than silently wrong.
// Ports:
//   bcd      in  4-bit BCD digit
//   segments out 7-bit glyph, bit0 = a ... bit6 = g, active-low
`timescale 1ns/1ps
module bcd_to_segments
  import seven_segment_scanner_pkg::*;
(
  input  logic [BCD_WIDTH-1:0]     bcd,
  output logic [SEGMENT_WIDTH-1:0] segments
);

  always_comb begin
    segments = GLYPH_DASH;
    case (bcd)
      4'd0:    segments = GLYPH_0;
      4'd1:    segments = GLYPH_1;
      4'd2:    segments = GLYPH_2;
      4'd3:    segments = GLYPH_3;
      4'd4:    segments = GLYPH_4;
      4'd5:    segments = GLYPH_5;
      4'd6:    segments = GLYPH_6;
      4'd7:    segments = GLYPH_7;
      4'd8:    segments = GLYPH_8;
      4'd9:    segments = GLYPH_9;
      default: segments = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
// Time-multiplexed driver for a common-anode multi-digit seven-segment
// display. A frame-coherent snapshot of the packed BCD value is scanned one
// digit per slot; each slot starts with an all-off interval to suppress
// ghosting. Optional leading-zero blanking and a colon on digit 2.
// Ports:
//   clk                 in  system clock
//   rst                 in  asynchronous reset, active-low
//   number              in  packed BCD, digit i at [4i+3:4i]
//   blank_leading_zeros in  1 = blank leading zero digits (live)
//   colon_on            in  1 = light dp on digit 2 (live)
//   segments            out glyph of the selected digit, active-low
//   dp                  out decimal point, active-low
//   digit_select        out one-cold digit enable, active-low
`timescale 1ns/1ps
module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int NUMBER_OF_DIGITS            = 4,
  parameter int NUMBER_OF_BITS_PER_DIGIT    = 4,
  parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int FRAME_RATE_IN_HZ            = 1000,
  parameter int BLANK_CYCLES                = 250
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] number,
  input  logic                                                 blank_leading_zeros,
  input  logic                                                 colon_on,
  output logic [SEGMENT_WIDTH-1:0]                             segments,
  output logic                                                 dp,
  output logic [NUMBER_OF_DIGITS-1:0]                          digit_select
);

  localparam int N               = NUMBER_OF_DIGITS;
  localparam int B               = NUMBER_OF_BITS_PER_DIGIT;
  localparam int SLOT_CYCLES     = slot_cycles(BOARD_CLOCK_FREQUENCY_IN_HZ,
                                               FRAME_RATE_IN_HZ, N);
  localparam int PRESCALER_WIDTH = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int INDEX_WIDTH     = (N > 1) ? $clog2(N) : 1;

  localparam logic [PRESCALER_WIDTH-1:0] PRESCALER_LAST = PRESCALER_WIDTH'(SLOT_CYCLES - 1);
  localparam logic [PRESCALER_WIDTH-1:0] BLANK_LIMIT    = PRESCALER_WIDTH'(BLANK_CYCLES);
  localparam logic [INDEX_WIDTH-1:0]     INDEX_LAST     = INDEX_WIDTH'(N - 1);
  localparam logic [INDEX_WIDTH-1:0]     COLON_INDEX    = INDEX_WIDTH'(COLON_DIGIT);

  logic [PRESCALER_WIDTH-1:0] prescaler_reg;
  logic [INDEX_WIDTH-1:0]     index_reg;
  logic [N*B-1:0]             snapshot_reg;
  logic [SEGMENT_WIDTH-1:0]   segments_reg, segments_next;
  logic                       dp_reg, dp_next;
  logic [N-1:0]               digit_select_reg, digit_select_next;

  logic [B-1:0]               digit_values [N];
  logic [N-1:0]               suppressed;
  logic [SEGMENT_WIDTH-1:0]   glyph;
  logic                       all_zero_above;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_digit
      assign digit_values[gi] = snapshot_reg[gi*B +: B];
    end
  endgenerate

  // Digit i is a leading zero when it and every more-significant digit are
  // zero. Digit 0 always shows so a zero value never leaves a dark display.
  always_comb begin
    all_zero_above = 1'b1;
    suppressed     = '0;
    for (int i = N - 1; i >= 1; i--) begin
      all_zero_above = all_zero_above && (digit_values[i] == '0);
      suppressed[i]  = blank_leading_zeros && all_zero_above;
    end
  end

  bcd_to_segments u_decoder (
    .bcd      (digit_values[index_reg]),
    .segments (glyph)
  );

  // Output values computed from the current scan state; the output
  // registers add the single cycle of latency.
  always_comb begin
    segments_next     = GLYPH_OFF;
    dp_next           = 1'b1;
    digit_select_next = '1;
    if ((prescaler_reg >= BLANK_LIMIT) && !suppressed[index_reg]) begin
      segments_next     = glyph;
      dp_next           = !(colon_on && (index_reg == COLON_INDEX));
      digit_select_next = ~(N'(1) << index_reg);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler_reg    <= '0;
      index_reg        <= '0;
      snapshot_reg     <= '0;
      segments_reg     <= GLYPH_OFF;
      dp_reg           <= 1'b1;
      digit_select_reg <= '1;
    end else begin
      if (prescaler_reg == PRESCALER_LAST) begin
        prescaler_reg <= '0;
        index_reg     <= (index_reg == INDEX_LAST) ? '0 : index_reg + INDEX_WIDTH'(1);
      end else begin
        prescaler_reg <= prescaler_reg + PRESCALER_WIDTH'(1);
      end
      // Capture once per frame, while digit 0 is still blanked, so a whole
      // frame shows one coherent value.
      if ((prescaler_reg == '0) && (index_reg == '0)) begin
        snapshot_reg <= number;
      end
      segments_reg     <= segments_next;
      dp_reg           <= dp_next;
      digit_select_reg <= digit_select_next;
    end
  end

  assign segments     = segments_reg;
  assign dp           = dp_reg;
  assign digit_select = digit_select_reg;

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed 4-digit seven-segment driver sitting directly downstream of the stopwatch counter. It consumes the packed BCD MM:SS value the counter produces and scans one digit at a time onto a common-anode display. Each scan slot has a ghost-suppression blanking interval, optional leading-zero suppression and a colon (decimal point) indicator. All display outputs are registered and active-low.

## Interface
- NUMBER_OF_DIGITS, 4, digits scanned; digit 0 = seconds_1, digit 3 = minutes_10
- NUMBER_OF_BITS_PER_DIGIT, 4, BCD width per digit
- BOARD_CLOCK_FREQUENCY_IN_HZ, 100_000_000, clk frequency
- FRAME_RATE_IN_HZ, 1000, full scans of all digits per second
- BLANK_CYCLES, 250, all-digits-off cycles at start of each slot; legal range 1..SLOT_CYCLES-1
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- number  input  NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT  packed BCD, digit i at bits [4i+3:4i]
- blank_leading_zeros  input  1  1 = suppress leading zeros
- colon_on  input  1  1 = light dp while digit 2 is selected
- segments  output  7  bit0=a … bit6=g, active-low
- dp  output  1  decimal point, active-low
- digit_select  output  NUMBER_OF_DIGITS  one-cold digit enable, active-low

## Operation
- SLOT_CYCLES = BOARD_CLOCK_FREQUENCY_IN_HZ / (FRAME_RATE_IN_HZ * NUMBER_OF_DIGITS), integer division.
- Prescaler counts 0..SLOT_CYCLES-1, then wraps to 0. On wrap, index advances 0→1→…→N-1→0.
- Snapshot register loads `number` on every cycle where prescaler==0 and index==0, including the first cycle after reset release. A frame displays a single coherent value; mid-frame input changes take effect at the next frame.
- Slot phase:
  - prescaler < BLANK_CYCLES → blank phase: digit_select all 1s, segments 7'h7F, dp 1.
  - Otherwise → active phase: digit_select bit[index]=0, others 1.
- Segment decode of the snapshot digit:
  - 0–9 → standard glyphs. Values used in the test plan: 0=7'h40, 1=7'h79, 4=7'h19, 7=7'h78.
  - 10–15 → dash, 7'h3F.
- Leading-zero suppression: digit i (i>0) is suppressed when blank_leading_zeros=1 and snapshot digits i..N-1 are all zero. A suppressed digit keeps digit_select all 1s through its whole slot. Digit 0 is never suppressed.
- dp=0 only in the active phase of index 2 with colon_on=1. colon_on and blank_leading_zeros are sampled live, not snapshotted. When digit 2 is suppressed, the colon is suppressed with it.

## Timing
- Reset (rst=0, asynchronous): prescaler 0, index 0, snapshot 0, segments 7'h7F, dp 1, digit_select all 1s.
- Outputs are registered: they reflect the prescaler/index/snapshot state of the previous cycle, so latency is 1 clk.
- First cycle after reset release: snapshot loads and outputs hold blank.
- Active phase of digit 0 appears on outputs BLANK_CYCLES+1 cycles after release.
- Active phase per slot lasts SLOT_CYCLES-BLANK_CYCLES cycles. Frame length is N*SLOT_CYCLES.
- Reset asserted mid-frame: outputs go to reset values immediately, without waiting for clk. Scanning restarts at digit 0 with a fresh snapshot.
- Each digit_select transition is always separated by at least BLANK_CYCLES all-off cycles; two digits are never enabled simultaneously.

## Structure
- Shared package:
  - seven-segment glyph constants (0–9, dash, off)
  - SEGMENT_WIDTH = 7
  - SLOT_CYCLES derivation function
- Sub-module bcd_to_segments: combinational 4-bit BCD → 7-bit active-low glyph, dash for values >9. Reused by other display paths.
- Top level holds prescaler, index counter, snapshot register, suppression logic and the output registers.

## Test plan
Bench parameters: BOARD_CLOCK_FREQUENCY_IN_HZ=80, FRAME_RATE_IN_HZ=1, BLANK_CYCLES=2, so SLOT_CYCLES=20.
- Reset: hold rst=0 → segments 7'h7F, dp 1, digit_select 4'hF. Release with number=16'h1234 → cycles 1–3 blank; cycle 4 digit_select 4'hE, segments 7'h19.
- Full frame on 16'h1234 → slots show E/19, D/3-glyph, B/2-glyph, 7/79. Each slot has 18 active cycles and 2 blank cycles; pattern repeats every 80 cycles.
- Tearing: number=16'h0059, switched to 16'h0100 during slot 1 → remaining slots show 0,0; the next frame shows 0,0,1,0.
- Leading zeros, blank_leading_zeros=1:
  - 16'h0007 → digits 1–3 never selected; digit 0 shows 7'h78.
  - 16'h0000 → digit 0 shows 7'h40.
- Invalid digit and colon: 16'h00A0 → digit 1 shows 7'h3F. colon_on=1 → dp=0 only during digit 2's active cycles.
- Mid-frame reset: assert rst during slot 2 → outputs blank immediately, without waiting for clk. After release, scanning restarts at digit 0 after 3 blank cycles.
